// File: rtl/requant_pkg.sv
// Shared constants, rounding-mode encoding and saturation bounds for the
// INT32 -> INTn requantizer.
package requant_pkg;

  localparam int unsigned FRAC_BITS_DEF = 24;

  typedef enum logic {
    RND_HALF_UP = 1'b0,
    RND_FLOOR   = 1'b1
  } rnd_mode_e;

  function automatic int sat_min(input int unsigned out_w);
    return -(1 << (out_w - 1));
  endfunction

  function automatic int sat_max(input int unsigned out_w);
    return (1 << (out_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/requant_lane.sv
// One requantizer lane: input regs, MULT_STAGES-deep exact multiply, round,
// then ReLU / zero-point / clamp into the output register.
module requant_lane
  import requant_pkg::*;
#(
  parameter int unsigned IN_W        = 32,
  parameter int unsigned SCALE_W     = 32,
  parameter int unsigned FRAC_BITS   = FRAC_BITS_DEF,
  parameter int unsigned OUT_W       = 8,
  parameter int unsigned MULT_STAGES = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               c_load,
  input  logic [IN_W-1:0]    acc,
  input  logic [SCALE_W-1:0] scale,
  input  logic [OUT_W-1:0]   zp,
  input  logic               relu,
  input  logic               trunc,
  output logic [OUT_W-1:0]   q,
  output logic               sat
);

  localparam int unsigned PW = IN_W + SCALE_W + 1;
  localparam int unsigned VW = PW + 1;
  localparam int unsigned LAST = MULT_STAGES - 1;
  localparam logic signed [PW-1:0] HALF = PW'(1) << (FRAC_BITS - 1);
  localparam logic signed [VW-1:0] SAT_LO = VW'(sat_min(OUT_W));
  localparam logic signed [VW-1:0] SAT_HI = VW'(sat_max(OUT_W));

  logic [IN_W-1:0]    acc_q, acc_d;
  logic [SCALE_W-1:0] scale_q, scale_d;
  logic [OUT_W-1:0]   zp_q, zp_d;
  logic               relu_q, relu_d;
  rnd_mode_e          rnd_q, rnd_d;

  logic signed [PW-1:0] prod_q [MULT_STAGES];
  logic signed [PW-1:0] prod_d [MULT_STAGES];
  logic [OUT_W-1:0]     zp_m_q [MULT_STAGES];
  logic [OUT_W-1:0]     zp_m_d [MULT_STAGES];
  logic                 relu_m_q [MULT_STAGES];
  logic                 relu_m_d [MULT_STAGES];
  rnd_mode_e            rnd_m_q [MULT_STAGES];
  rnd_mode_e            rnd_m_d [MULT_STAGES];

  logic signed [PW-1:0] r_q, r_d;
  logic signed [PW-1:0] rnd_add;
  logic [OUT_W-1:0]     zp_r_q, zp_r_d;
  logic                 relu_r_q, relu_r_d;

  logic signed [PW-1:0] rr;
  logic signed [VW-1:0] v;
  logic [OUT_W-1:0]     q_q, q_d;
  logic                 sat_q, sat_d;

  always_comb begin
    acc_d   = acc;
    scale_d = scale;
    zp_d    = zp;
    relu_d  = relu;
    rnd_d   = trunc ? RND_FLOOR : RND_HALF_UP;
  end

  // Operands widened to the full product width so the multiply is exact;
  // later stages only delay the product alongside its per-vector config.
  always_comb begin
    prod_d[0]   = PW'($signed(acc_q)) * PW'($signed({1'b0, scale_q}));
    zp_m_d[0]   = zp_q;
    relu_m_d[0] = relu_q;
    rnd_m_d[0]  = rnd_q;
    for (int unsigned k = 1; k < MULT_STAGES; k++) begin
      prod_d[k]   = prod_q[k-1];
      zp_m_d[k]   = zp_m_q[k-1];
      relu_m_d[k] = relu_m_q[k-1];
      rnd_m_d[k]  = rnd_m_q[k-1];
    end
  end

  always_comb begin
    rnd_add = '0;
    if (rnd_m_q[LAST] == RND_HALF_UP) rnd_add = HALF;
    r_d      = (prod_q[LAST] + rnd_add) >>> FRAC_BITS;
    zp_r_d   = zp_m_q[LAST];
    relu_r_d = relu_m_q[LAST];
  end

  always_comb begin
    rr = r_q;
    if (relu_r_q && (r_q < 0)) rr = '0;
    v     = VW'(rr) + VW'($signed(zp_r_q));
    q_d   = v[OUT_W-1:0];
    sat_d = 1'b0;
    if (v > SAT_HI) begin
      q_d   = SAT_HI[OUT_W-1:0];
      sat_d = 1'b1;
    end else if (v < SAT_LO) begin
      q_d   = SAT_LO[OUT_W-1:0];
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      acc_q    <= acc_d;
      scale_q  <= scale_d;
      zp_q     <= zp_d;
      relu_q   <= relu_d;
      rnd_q    <= rnd_d;
      prod_q   <= prod_d;
      zp_m_q   <= zp_m_d;
      relu_m_q <= relu_m_d;
      rnd_m_q  <= rnd_m_d;
      r_q      <= r_d;
      zp_r_q   <= zp_r_d;
      relu_r_q <= relu_r_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q   <= '0;
      sat_q <= 1'b0;
    end else if (c_load) begin
      q_q   <= q_d;
      sat_q <= sat_d;
    end
  end

  assign q   = q_q;
  assign sat = sat_q;

endmodule

// File: rtl/requant_lanes_pipeline.sv
// LANES-wide requantizer: per-lane datapaths share one valid shift register
// and a single whole-pipeline stall driven by output backpressure.
module requant_lanes_pipeline
  import requant_pkg::*;
#(
  parameter int unsigned LANES       = 4,
  parameter int unsigned IN_W        = 32,
  parameter int unsigned SCALE_W     = 32,
  parameter int unsigned FRAC_BITS   = FRAC_BITS_DEF,
  parameter int unsigned OUT_W       = 8,
  parameter int unsigned MULT_STAGES = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*IN_W-1:0]    in_acc,
  input  logic [LANES*SCALE_W-1:0] cfg_scale,
  input  logic [LANES*OUT_W-1:0]   cfg_zp,
  input  logic                     cfg_relu,
  input  logic                     cfg_trunc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*OUT_W-1:0]   out_q,
  output logic [LANES-1:0]         sat_flag
);

  localparam int unsigned DEPTH = MULT_STAGES + 3;

  logic [DEPTH-1:0] vld_q, vld_d;
  logic             stall;
  logic             en;
  logic             c_load;

  assign out_valid = vld_q[DEPTH-1];
  assign stall     = out_valid & ~out_ready;
  assign en        = ~stall;
  assign in_ready  = en;
  // The output register only reloads when a real vector arrives from R.
  assign c_load    = en & vld_q[DEPTH-2];

  always_comb begin
    vld_d = vld_q;
    if (en) vld_d = {vld_q[DEPTH-2:0], in_valid};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vld_q <= '0;
    else          vld_q <= vld_d;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    requant_lane #(
      .IN_W        (IN_W),
      .SCALE_W     (SCALE_W),
      .FRAC_BITS   (FRAC_BITS),
      .OUT_W       (OUT_W),
      .MULT_STAGES (MULT_STAGES)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
      .c_load  (c_load),
      .acc     (in_acc[i*IN_W +: IN_W]),
      .scale   (cfg_scale[i*SCALE_W +: SCALE_W]),
      .zp      (cfg_zp[i*OUT_W +: OUT_W]),
      .relu    (cfg_relu),
      .trunc   (cfg_trunc),
      .q       (out_q[i*OUT_W +: OUT_W]),
      .sat     (sat_flag[i])
    );
  end

endmodule

// File: tb/tb_requant_lanes_pipeline.sv
// Self-checking bench for requant_lanes_pipeline: directed spec cases plus
// randomized streams scored against a plain-arithmetic reference model.
module tb_requant_lanes_pipeline;

  localparam int unsigned LANES = 4;
  localparam int unsigned IN_W = 32;
  localparam int unsigned SCALE_W = 32;
  localparam int unsigned FRAC_BITS = 24;
  localparam int unsigned OUT_W = 8;
  localparam int unsigned MULT_STAGES = 4;

  typedef struct {
    logic [LANES*IN_W-1:0]    acc;
    logic [LANES*SCALE_W-1:0] scale;
    logic [LANES*OUT_W-1:0]   zp;
    logic                     relu;
    logic                     trunc;
  } vec_t;

  typedef struct packed {
    logic [LANES*OUT_W-1:0] q;
    logic [LANES-1:0]       sat;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic in_valid;
  logic in_ready;
  logic [LANES*IN_W-1:0] in_acc;
  logic [LANES*SCALE_W-1:0] cfg_scale;
  logic [LANES*OUT_W-1:0] cfg_zp;
  logic cfg_relu, cfg_trunc;
  logic out_valid;
  logic out_ready;
  logic [LANES*OUT_W-1:0] out_q;
  logic [LANES-1:0] sat_flag;

  int total = 0;
  int bad = 0;
  exp_t exp_q[$];
  bit rdy_rand = 0;
  bit hold_chk = 0;
  logic [LANES*OUT_W-1:0] held_q;
  logic [LANES-1:0] held_s;

  always #5 clk = ~clk;

  requant_lanes_pipeline #(
    .LANES       (LANES),
    .IN_W        (IN_W),
    .SCALE_W     (SCALE_W),
    .FRAC_BITS   (FRAC_BITS),
    .OUT_W       (OUT_W),
    .MULT_STAGES (MULT_STAGES)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_acc    (in_acc),
    .cfg_scale (cfg_scale),
    .cfg_zp    (cfg_zp),
    .cfg_relu  (cfg_relu),
    .cfg_trunc (cfg_trunc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .sat_flag  (sat_flag)
  );

  // Value = acc * scale / 2^FRAC_BITS, rounded half up or floored, then
  // ReLU, zero-point and clamp to the signed OUT_W range.
  function automatic exp_t ref_model(input vec_t v);
    exp_t e;
    longint lo, hi;
    lo = -(64'sd1 <<< (OUT_W - 1));
    hi = (64'sd1 <<< (OUT_W - 1)) - 1;
    e = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      longint a, s, p, r;
      a = longint'($signed(v.acc[i*IN_W +: IN_W]));
      s = longint'({32'd0, v.scale[i*SCALE_W +: SCALE_W]});
      p = a * s;
      if (!v.trunc) p = p + (64'sd1 <<< (FRAC_BITS - 1));
      r = p >>> FRAC_BITS;
      if (v.relu && r < 0) r = 0;
      r = r + longint'($signed(v.zp[i*OUT_W +: OUT_W]));
      if (r > hi) begin r = hi; e.sat[i] = 1'b1; end
      else if (r < lo) begin r = lo; e.sat[i] = 1'b1; end
      e.q[i*OUT_W +: OUT_W] = r[OUT_W-1:0];
    end
    return e;
  endfunction

  function automatic vec_t rand_vec(input bit wide);
    vec_t v;
    for (int i = 0; i < int'(LANES); i++) begin
      v.acc[i*IN_W +: IN_W] = wide ? $urandom : 32'($urandom_range(0, 8000)) - 32'd4000;
      v.scale[i*SCALE_W +: SCALE_W] = wide ? $urandom : $urandom_range(0, 32'h0200_0000);
      v.zp[i*OUT_W +: OUT_W] = 8'($urandom_range(0, 255));
    end
    v.relu = 1'($urandom_range(0, 1));
    v.trunc = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic vec_t mk_vec(input int a0, input int a1, input int a2, input int a3,
                                  input logic [31:0] sc, input int zp0, input int zp1,
                                  input logic relu, input logic trunc);
    vec_t v;
    v.acc = {32'(a3), 32'(a2), 32'(a1), 32'(a0)};
    v.scale = {sc, sc, sc, sc};
    v.zp = {8'd0, 8'd0, 8'(zp1), 8'(zp0)};
    v.relu = relu;
    v.trunc = trunc;
    return v;
  endfunction

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (hold_chk) begin
        total++;
        assert (out_valid === 1'b1 && out_q === held_q && sat_flag === held_s) else begin
          bad++;
          $error("FAIL stall_hold got v=%b q=%h s=%b exp v=1 q=%h s=%b",
                 out_valid, out_q, sat_flag, held_q, held_s);
        end
      end
      hold_chk = out_valid & ~out_ready;
      held_q = out_q;
      held_s = sat_flag;
      if (out_valid && out_ready) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_out got q=%h exp no output", out_q);
        end
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          total++;
          assert (out_q === e.q && sat_flag === e.sat) else begin
            bad++;
            $error("FAIL out_vec got q=%h s=%b exp q=%h s=%b", out_q, sat_flag, e.q, e.sat);
          end
        end
      end
      if (in_valid && in_ready) begin
        vec_t v;
        v.acc = in_acc; v.scale = cfg_scale; v.zp = cfg_zp;
        v.relu = cfg_relu; v.trunc = cfg_trunc;
        exp_q.push_back(ref_model(v));
      end
    end else begin
      hold_chk = 0;
    end
  end

  task automatic send(input vec_t v);
    int n;
    bit ok;
    in_acc = v.acc; cfg_scale = v.scale; cfg_zp = v.zp;
    cfg_relu = v.relu; cfg_trunc = v.trunc; in_valid = 1'b1;
    n = 0; ok = 0;
    while (!ok && n < 200) begin
      if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    total++;
    assert (ok) else begin bad++; $error("FAIL send_timeout got %0d exp 1", ok); end
  endtask

  task automatic one_shot(input vec_t v, output logic [31:0] q, output logic [3:0] s,
                          output int lat);
    int n;
    send(v);
    n = 1;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    q = out_q; s = sat_flag; lat = n;
  endtask

  task automatic drain();
    int n;
    n = 0; rdy_rand = 0; out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin @(posedge clk); #1; n++; end
    total++;
    assert (exp_q.size() == 0 && out_valid === 1'b0) else begin
      bad++;
      $error("FAIL drain got pending=%0d v=%b exp 0 0", exp_q.size(), out_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] q;
    logic [3:0] s;
    int lat;

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_acc = '0; cfg_scale = '0; cfg_zp = '0; cfg_relu = 1'b0; cfg_trunc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    assert (out_valid === 1'b0 && out_q === '0 && sat_flag === '0 && in_ready === 1'b1) else begin
      bad++;
      $error("FAIL reset_state got v=%b q=%h s=%b r=%b exp 0 0 0 1", out_valid, out_q, sat_flag, in_ready);
    end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;

    one_shot(mk_vec(100, -100, 0, 127, 32'h0100_0000, 0, 0, 0, 0), q, s, lat);
    total++;
    assert (q === 32'h7F00_9C64 && s === 4'b0000) else begin
      bad++; $error("FAIL unity_scale got q=%h s=%b exp q=7f009c64 s=0000", q, s);
    end
    total++;
    assert (lat === int'(MULT_STAGES) + 3) else begin
      bad++; $error("FAIL latency got %0d exp %0d", lat, MULT_STAGES + 3);
    end

    one_shot(mk_vec(3, -3, 1000, -1000, 32'h0080_0000, 0, 0, 0, 0), q, s, lat);
    total++;
    assert (q === 32'h807F_FF02 && s === 4'b1100) else begin
      bad++; $error("FAIL half_round got q=%h s=%b exp q=807fff02 s=1100", q, s);
    end
    one_shot(mk_vec(3, -3, 1000, -1000, 32'h0080_0000, 0, 0, 0, 1), q, s, lat);
    total++;
    assert (q === 32'h807F_FE01 && s === 4'b1100) else begin
      bad++; $error("FAIL half_trunc got q=%h s=%b exp q=807ffe01 s=1100", q, s);
    end

    one_shot(mk_vec(-50, 50, 0, 0, 32'h0100_0000, -20, 100, 1, 0), q, s, lat);
    total++;
    assert (q === 32'h0000_7FEC && s === 4'b0010) else begin
      bad++; $error("FAIL relu_zp got q=%h s=%b exp q=00007fec s=0010", q, s);
    end
    drain();

    rdy_rand = 1;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        rdy_rand = 0; out_ready = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rdy_rand = 1;
      end
      send(rand_vec(i % 4 == 3));
    end
    drain();

    for (int i = 0; i < 8; i++) begin
      vec_t v;
      v = rand_vec(0);
      v.scale = (i % 2 == 0) ? {4{32'h0100_0000}} : {4{32'h0040_0000}};
      send(v);
    end
    drain();

    rdy_rand = 1;
    for (int i = 0; i < 24; i++) send(rand_vec(i % 3 == 0));
    drain();

    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      assert (in_ready === 1'b1) else begin
        bad++; $error("FAIL idle_ready got %b exp 1", in_ready);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;

    for (int i = 0; i < 3; i++) send(rand_vec(0));
    reset_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    total++;
    assert (out_valid === 1'b0 && in_ready === 1'b1) else begin
      bad++; $error("FAIL reset_flush got v=%b r=%b exp 0 1", out_valid, in_ready);
    end
    @(negedge clk); reset_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      total++;
      assert (out_valid === 1'b0) else begin
        bad++; $error("FAIL stale_out got %b exp 0", out_valid);
      end
    end
    @(posedge clk); #1;
    send(rand_vec(0));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
